// File: rtl/serial_word_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_tx_pkg
//  Description : Shared types and helpers for the serial word transmitter.
//                - state_t   : transmitter FSM state encoding (IDLE, SHIFT)
//                - mod3_step : one-bit update of a running mod-3 remainder
//                              for an MSB-first binary stream
//  Revision    : 1.0  initial release
// ============================================================================
package serial_word_tx_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Appending bit b to a stream of value V gives 2*V + b, so the new
    // remainder is (2*rem + b) mod 3. Written as a table to keep it to a
    // handful of LUT inputs with no arithmetic.
    function automatic logic [1:0] mod3_step(input logic [1:0] rem, input logic bit_in);
        logic [1:0] nxt;
        nxt = 2'd0;
        case (rem)
            2'd0:    nxt = bit_in ? 2'd1 : 2'd0;
            2'd1:    nxt = bit_in ? 2'd0 : 2'd2;
            2'd2:    nxt = bit_in ? 2'd2 : 2'd1;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

endpackage : serial_word_tx_pkg
`default_nettype wire

// File: rtl/serial_word_tx_mod3_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : mod3_tracker
//  Description : Running mod-3 remainder of the serial stream sent since
//                reset, with a divisibility flag aligned to the current bit.
//  Ports       :
//    clk      in   clock, all logic on posedge
//    reset    in   synchronous, active-high; clears the remainder
//    bit_vld  in   x carries a data bit this cycle
//    x        in   current serial bit (MSB-first stream)
//    exp_div  out  stream value including the current bit is divisible by 3
//  Revision    : 1.0  initial release
// ============================================================================
module mod3_tracker
    import serial_word_tx_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic bit_vld,
    input  logic x,
    output logic exp_div
);

    logic [1:0] r_rem;
    logic [1:0] w_nxt;

    assign w_nxt = mod3_step(r_rem, x);

    // Remainder spans word boundaries; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem <= 2'd0;
        end else if (bit_vld) begin
            r_rem <= w_nxt;
        end
    end

    // The flag already includes the bit on the line this cycle, so a
    // downstream serial checker can be compared against it combinationally.
    always_comb begin
        exp_div = 1'b1;
        if (!reset) begin
            exp_div = bit_vld ? (w_nxt == 2'd0) : (r_rem == 2'd0);
        end
    end

endmodule : mod3_tracker
`default_nettype wire

// File: rtl/serial_word_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_tx
//  Description : Parallel-to-serial transmitter. Takes WIDTH-bit words on a
//                valid/ready handshake and shifts them out MSB-first, one bit
//                per clock, with back-to-back reload on the LSB cycle.
//                Optional reference mod-3 tracker enabled by MOD3_REF_EN.
//  Parameters  :
//    WIDTH      bits per word (>= 2)
//  Ports       :
//    clk        in   clock, all logic on posedge
//    reset      in   synchronous, active-high
//    data_i     in   word to send, sampled on handshake only
//    valid_i    in   source has a word
//    ready_o    out  block can accept a word this cycle
//    x_o        out  serial bit, MSB first; 0 when no bit is valid
//    bit_vld_o  out  x_o carries a data bit
//    last_o     out  current bit is the LSB of its word
//    busy_o     out  FSM in SHIFT
//    exp_div_o  out  stream-so-far divisible by 3 (MOD3_REF_EN only, else 0)
//  Macro       : MOD3_REF_EN  - instantiates mod3_tracker
//  Revision    : 1.0  initial release
// ============================================================================
module serial_word_tx
    import serial_word_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             x_o,
    output logic             bit_vld_o,
    output logic             last_o,
    output logic             busy_o,
    output logic             exp_div_o
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sr;
    logic [CNT_W-1:0] r_cnt;

    logic w_cnt_zero;
    logic w_shift;
    logic w_hs;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_shift    = !reset && (r_state == SHIFT);

    // Ready in IDLE, or on the LSB cycle so the next word follows without a
    // bubble.
    assign ready_o = !reset && ((r_state == IDLE) || ((r_state == SHIFT) && w_cnt_zero));
    assign w_hs    = valid_i && ready_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_sr    <= data_i;
                        r_cnt   <= C_CNT_LOAD;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_cnt_zero) begin
                        if (w_hs) begin
                            r_sr    <= data_i;
                            r_cnt   <= C_CNT_LOAD;
                        end else begin
                            r_sr    <= '0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_sr  <= {r_sr[WIDTH-2:0], 1'b0};
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o    = w_shift;
    assign bit_vld_o = w_shift;
    assign x_o       = w_shift && r_sr[WIDTH-1];
    assign last_o    = w_shift && w_cnt_zero;

`ifdef MOD3_REF_EN
    mod3_tracker u_mod3_tracker (
        .clk     (clk),
        .reset   (reset),
        .bit_vld (bit_vld_o),
        .x       (x_o),
        .exp_div (exp_div_o)
    );
`else
    assign exp_div_o = 1'b0;
`endif

endmodule : serial_word_tx
`default_nettype wire

// File: tb/tb_serial_word_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_word_tx
//  Description : Self-checking bench for serial_word_tx (WIDTH=8).
//                Table of single words with hand-computed divisibility
//                sequences, plus back-to-back, reset-abort, valid-drop and a
//                short random stream against a mod-3 reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_word_tx;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] data_i;
    logic             valid_i;
    logic             ready_o;
    logic             x_o;
    logic             bit_vld_o;
    logic             last_o;
    logic             busy_o;
    logic             exp_div_o;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    serial_word_tx #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .x_o       (x_o),
        .bit_vld_o (bit_vld_o),
        .last_o    (last_o),
        .busy_o    (busy_o),
        .exp_div_o (exp_div_o)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] div_seq;   // bit 7 = expected flag on the MSB cycle
    } vec_t;

    // Without the reference tracker the flag is tied low.
    function automatic logic ed(input logic v);
`ifdef MOD3_REF_EN
        return v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        valid_i = 1'b0;
        data_i  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready_o, 0);
        chk("rst_vld", bit_vld_o, 0);
        chk("rst_div", exp_div_o, ed(1'b1));
        reset = 1'b0;
        #1;
        chk("post_rst_ready", ready_o, 1);
        chk("post_rst_x", x_o, 0);
        chk("post_rst_vld", bit_vld_o, 0);
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_div", exp_div_o, ed(1'b1));
    endtask

    // Sends one word from IDLE and checks all its bits; valid drops after
    // the handshake and data_i is scrambled while the word shifts.
    task automatic send_word(input logic [7:0] d, input logic [7:0] dseq);
        @(negedge clk);
        data_i  = d;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            chk("w_vld", bit_vld_o, 1);
            chk("w_x", x_o, d[WIDTH-1-i]);
            chk("w_last", last_o, (i == WIDTH - 1));
            chk("w_div", exp_div_o, ed(dseq[WIDTH-1-i]));
            data_i = 8'($urandom);
            if (i < WIDTH - 1) @(negedge clk);
        end
        @(negedge clk);
        chk("w_idle_vld", bit_vld_o, 0);
        chk("w_idle_busy", busy_o, 0);
        chk("w_idle_x", x_o, 0);
    endtask

    vec_t vecs[6];

    initial begin
        logic [1:0]  rem;
        logic [1:0]  nxt;
        logic [7:0]  words[20];
        logic [15:0] b2b_x;
        logic [15:0] b2b_div;

        vecs[0] = '{8'h03, 8'b1111_1101};
        vecs[1] = '{8'hFF, 8'b0101_0101};
        vecs[2] = '{8'h00, 8'b1111_1111};
        vecs[3] = '{8'hA5, 8'b0000_0001};
        vecs[4] = '{8'h81, 8'b0000_0001};
        vecs[5] = '{8'h06, 8'b1111_1011};

        // Table: each word starts from a cleared remainder.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            send_word(vecs[v].data, vecs[v].div_seq);
        end

        // Back-to-back 0xFF then 0x00 from remainder 0.
        do_reset();
        b2b_x   = 16'hFF00;
        b2b_div = 16'b0101_0101_1111_1111;
        @(negedge clk);
        data_i  = 8'hFF;
        valid_i = 1'b1;
        @(negedge clk);
        data_i  = 8'h00;
        for (int j = 0; j < 16; j++) begin
            chk("b2b_vld", bit_vld_o, 1);
            chk("b2b_x", x_o, b2b_x[15-j]);
            chk("b2b_ready", ready_o, (j == 7 || j == 15));
            chk("b2b_last", last_o, (j == 7 || j == 15));
            chk("b2b_div", exp_div_o, ed(b2b_div[15-j]));
            if (j == 8) valid_i = 1'b0;
            if (j < 15) @(negedge clk);
        end
        @(negedge clk);
        chk("b2b_end_vld", bit_vld_o, 0);

        // Reset during bit 4 of 0xA5 aborts the word and clears the remainder.
        do_reset();
        @(negedge clk);
        data_i  = 8'hA5;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_pre_x", x_o, 0);   // bit 4 of 1010_0101
        chk("abort_pre_vld", bit_vld_o, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_vld", bit_vld_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_div", exp_div_o, ed(1'b1));
        chk("abort_ready", ready_o, 1);
        send_word(8'h03, 8'b1111_1101);
        @(negedge clk);
        chk("abort_after_vld", bit_vld_o, 0);

        // Valid held only for the handshake; later valid/data on non-ready
        // cycles must be ignored and the FSM returns to IDLE after the LSB.
        do_reset();
        @(negedge clk);
        data_i  = 8'h5A;
        valid_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < WIDTH; i++) begin
            chk("hold_x", x_o, (8'h5A >> (WIDTH - 1 - i)) & 1);
            chk("hold_div", exp_div_o, ed((8'b1000_0011 >> (WIDTH - 1 - i)) & 1));
            data_i  = 8'($urandom);
            valid_i = (i < WIDTH - 2);
            if (i < WIDTH - 1) @(negedge clk);
        end
        @(negedge clk);
        chk("hold_idle_vld", bit_vld_o, 0);
        @(negedge clk);
        chk("hold_idle_busy", busy_o, 0);

        // Random back-to-back stream against a mod-3 reference.
        do_reset();
        for (int w = 0; w < 20; w++) words[w] = 8'($urandom);
        rem = 2'd0;
        @(negedge clk);
        data_i  = words[0];
        valid_i = 1'b1;
        @(negedge clk);
        for (int w = 0; w < 20; w++) begin
            if (w < 19) data_i = words[w+1];
            else        valid_i = 1'b0;
            for (int b = 0; b < WIDTH; b++) begin
                nxt = 2'(({30'd0, rem} * 2 + {31'd0, words[w][WIDTH-1-b]}) % 3);
                chk("rnd_vld", bit_vld_o, 1);
                chk("rnd_x", x_o, words[w][WIDTH-1-b]);
                chk("rnd_div", exp_div_o, ed(nxt == 2'd0));
                rem = nxt;
                @(negedge clk);
            end
        end
        chk("rnd_end_vld", bit_vld_o, 0);
        chk("rnd_end_div", exp_div_o, ed(rem == 2'd0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_serial_word_tx
`default_nettype wire
